// File: rtl/modulo_prueba_cnt.sv
// Prescaled modulo up-counter: advances count_o once every DIV clocks, wrapping after MAX_COUNT.
// Build option: define MODULO_PRUEBA_SAT_EN to make the counter stop at MAX_COUNT instead of wrapping.
module modulo_prueba_cnt #(
    parameter int DIV       = 10,
    parameter int MAX_COUNT = 59
) (
    input  logic       clk,
    input  logic       rst,
    output logic [5:0] count_o
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [5:0]       CNT_LAST = 6'(MAX_COUNT);

    generate
        if (DIV < 1 || MAX_COUNT < 1 || MAX_COUNT > 63) begin : g_bad_param
            $error("modulo_prueba_cnt: illegal parameters DIV=%0d MAX_COUNT=%0d", DIV, MAX_COUNT);
        end
    endgenerate

    logic [PRE_W-1:0] pre_q;
    logic [5:0]       cnt_q;
    logic [5:0]       cnt_nxt;
    logic             tick;

    // With DIV=1 the compare is against zero and pre_q never leaves 0, so tick stays high.
    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    always_comb begin
        cnt_nxt = cnt_q;
        if (tick) begin
            // >= keeps cnt_q inside 0..MAX_COUNT even if it were ever disturbed.
            if (cnt_q >= CNT_LAST) begin
`ifdef MODULO_PRUEBA_SAT_EN
                cnt_nxt = CNT_LAST;
`else
                cnt_nxt = 6'd0;
`endif
            end else begin
                cnt_nxt = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 6'd0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: tb/tb_modulo_prueba_cnt.sv
// Directed bench for modulo_prueba_cnt: default instance (DIV=10, MAX=59) plus a DIV=1, MAX=5 instance.
module tb_modulo_prueba_cnt;

    logic       clk;
    logic       rst;
    logic [5:0] count_main;
    logic [5:0] count_small;

    int n_vec  = 0;
    int n_bad  = 0;
    int edge_n = 0;

    modulo_prueba_cnt #(.DIV(10), .MAX_COUNT(59)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .count_o (count_main)
    );

    modulo_prueba_cnt #(.DIV(1), .MAX_COUNT(5)) u_dut_small (
        .clk     (clk),
        .rst     (rst),
        .count_o (count_small)
    );

    // 50 MHz: rising edges at 10, 30, 50, ... ns
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) step();
    endtask

    // Reset asserted and released on falling edges; edge_n counts edges after release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_main", count_main, 6'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;
    endtask

    logic [5:0] small_seq [7];

    initial begin
        small_seq = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd0, 6'd1};
        rst = 1'b0;

        // 30 ns reset pulse that starts before the first clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_before_edge_main", count_main, 6'd0);
        chk("rst_before_edge_small", count_small, 6'd0);
        #8;  // t=11, just after first edge with rst high
        chk("rst_hold_main_e1", count_main, 6'd0);
        #20; // t=31, after second edge
        chk("rst_hold_main_e2", count_main, 6'd0);
        chk("rst_hold_small", count_small, 6'd0);
        #1 rst = 1'b0; // t=32; next rising edge at 50 ns is edge 1
        edge_n = 0;

        // edges 1..9: main still 0; small instance runs 1,2,3,4,5,0,1
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("main_pre_e%0d", k), count_main, 6'd0);
            if (k <= 7)
                chk($sformatf("small_seq_e%0d", k), count_small, small_seq[k-1]);
        end
        step();
        chk("main_first_inc_e10", count_main, 6'd1);
        run_to(19);
        chk("main_e19", count_main, 6'd1);
        step();
        chk("main_e20", count_main, 6'd2);
        run_to(589);
        chk("main_e589", count_main, 6'd58);
        step();
        chk("main_max_e590", count_main, 6'd59);
        run_to(599);
        chk("main_e599", count_main, 6'd59);
        step();
`ifdef MODULO_PRUEBA_SAT_EN
        chk("sat_e600", count_main, 6'd59);
        run_to(1200);
        chk("sat_e1200", count_main, 6'd59);
`else
        chk("wrap_e600", count_main, 6'd0);
        run_to(610);
        chk("wrap_e610", count_main, 6'd1);
`endif

        // mid-count reset: count 23 with prescaler at 4, then a 3 ns pulse between edges
        do_reset();
        chk("rst_release_main", count_main, 6'd0);
        run_to(234);
        chk("mid_cnt_e234", count_main, 6'd23);
        #4 rst = 1'b1;
        #1;
        chk("mid_rst_async", count_main, 6'd0);
        #2 rst = 1'b0;
        edge_n = 0;
        run_to(9);
        chk("mid_restart_e9", count_main, 6'd0);
        step();
        chk("mid_restart_e10", count_main, 6'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got t=%0t expected < 200000", $time);
        $fatal(1);
    end

endmodule
